// File: rtl/core2_ctrl_pkg.sv
// Shared types and field positions for the Core2 issue controller.
// Holds the FSM encoding, default widths and command/operand field layout.
package core2_ctrl_pkg;

   localparam int C2_DATA_W  = 256;
   localparam int C2_OP_W    = C2_DATA_W / 2;
   localparam int C2_SEL_W   = 3;
   localparam int C2_CMD_W   = 8;
   localparam int C2_CNT_W   = 16;

   // Select field sits in the low bits of the command byte.
   localparam int C2_SEL_LSB = 0;

   // Operand pair layout: A in the low half, B in the high half.
   localparam int C2_OPA_LSB = 0;
   localparam int C2_OPB_LSB = C2_OP_W;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LATCH = 3'd2,
      ST_ISSUE = 3'd3,
      ST_WAIT  = 3'd4,
      ST_WRITE = 3'd5
   } c2_state_t;

endpackage

// File: rtl/core2_watchdog.sv
// WAIT-cycle watchdog for the Core2 issue controller: counts consecutive
// run cycles, flags a timeout on the LIMIT-th one and keeps a sticky error.
module core2_watchdog #(
   parameter int LIMIT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic timeout,
   output logic err_flag
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt;

   assign timeout = run && (cnt == CW'(LIMIT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         err_flag <= 1'b0;
      end else begin
         cnt <= (run && !timeout) ? cnt + 1'b1 : '0;
         if (timeout)
            err_flag <= 1'b1;
      end
   end

endmodule

// File: rtl/core2_issue_ctrl.sv
// One-operation-in-flight sequencer between the Core2 FIFOs and the multiplier.
// Optional watchdog on the WAIT state is enabled by defining CORE2_WATCHDOG_EN.
module core2_issue_ctrl
   import core2_ctrl_pkg::*;
#(
   parameter int DATA_W    = C2_DATA_W,
   parameter int OP_W      = DATA_W / 2,
   parameter int SEL_W     = C2_SEL_W,
   parameter int WD_CYCLES = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_empty,
   output logic                cmd_rd_en,
   input  logic [C2_CMD_W-1:0] cmd_data,
   input  logic                opd_empty,
   output logic                opd_rd_en,
   input  logic [DATA_W-1:0]   opd_data,
   output logic [OP_W-1:0]     core_a,
   output logic [OP_W-1:0]     core_b,
   output logic [SEL_W-1:0]    core_sel,
   output logic                core_start,
   input  logic                core_busy,
   input  logic [DATA_W-1:0]   core_result,
   input  logic                res_full,
   output logic                res_wr_en,
   output logic [DATA_W-1:0]   res_data,
   output logic                ctrl_idle,
   output logic                err_flag,
   output logic [C2_CNT_W-1:0] op_count
);

   if (WD_CYCLES < 2 || 2 * OP_W != DATA_W) begin : g_bad_cfg
      $error("core2_issue_ctrl: WD_CYCLES must be >= 2 and DATA_W == 2*OP_W");
   end

   c2_state_t state, state_nxt;
   logic      wait_armed;
   logic      capture;
   logic      wd_timeout;
   logic      pop, push;
   logic      unused_cmd_bits;

   assign unused_cmd_bits = ^cmd_data[C2_CMD_W-1:SEL_W];

   // Busy is not yet valid in the first WAIT cycle, so arm the compare one cycle in.
   assign capture   = (state == ST_WAIT) && wait_armed && !core_busy;
   assign ctrl_idle = (state == ST_IDLE);

   always_comb begin
      state_nxt  = state;
      pop        = 1'b0;
      push       = 1'b0;
      core_start = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!cmd_empty && !opd_empty) begin
               pop       = 1'b1;
               state_nxt = ST_FETCH;
            end
         end
         ST_FETCH: state_nxt = ST_LATCH;
         ST_LATCH: state_nxt = ST_ISSUE;
         ST_ISSUE: begin
            core_start = 1'b1;
            state_nxt  = ST_WAIT;
         end
         ST_WAIT: begin
            if (capture)
               state_nxt = ST_WRITE;
            else if (wd_timeout)
               state_nxt = ST_IDLE;
         end
         ST_WRITE: begin
            if (!res_full) begin
               push      = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Handshakes are masked during reset so nothing is popped or pushed into a reset.
   assign cmd_rd_en = pop && !rst;
   assign opd_rd_en = pop && !rst;
   assign res_wr_en = push && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         wait_armed <= 1'b0;
         core_a     <= '0;
         core_b     <= '0;
         core_sel   <= '0;
         res_data   <= '0;
         op_count   <= '0;
      end else begin
         state      <= state_nxt;
         wait_armed <= (state == ST_WAIT);
         if (state == ST_LATCH) begin
            core_sel <= cmd_data[C2_SEL_LSB +: SEL_W];
            core_a   <= opd_data[C2_OPA_LSB +: OP_W];
            core_b   <= opd_data[OP_W +: OP_W];
         end
         if (capture)
            res_data <= core_result;
         if (push)
            op_count <= op_count + 1'b1;
      end
   end

`ifdef CORE2_WATCHDOG_EN
   core2_watchdog #(
      .LIMIT (WD_CYCLES)
   ) u_wd (
      .clk      (clk),
      .rst      (rst),
      .run      ((state == ST_WAIT) && !capture),
      .timeout  (wd_timeout),
      .err_flag (err_flag)
   );
`else
   assign wd_timeout = 1'b0;
   assign err_flag   = 1'b0;
`endif

endmodule

// File: doc/core2_issue_ctrl.md
# core2_issue_ctrl

Sequencer for the Core2 multiplier path. Pops one command byte and one 256-bit operand pair from the Core2 command and input FIFOs, presents them to Core2 with a start pulse, and waits for Core2 to finish. It then pushes the 256-bit result into the Core2 output FIFO, honouring its full flag. It replaces free-running FIFO read enables with a strict one-operation-in-flight handshake, so commands and operands cannot slip out of alignment.

## Interface
- DATA_W, 256, operand-pair and result width
- OP_W, 128, single operand width (DATA_W/2)
- SEL_W, 3, Core2 select-line width
- WD_CYCLES, 1024, watchdog limit in WAIT cycles (used only with the watchdog macro)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_empty  in  1  command FIFO empty
- cmd_rd_en  out  1  command FIFO pop, one-cycle pulse
- cmd_data  in  8  command byte; [2:0] select, [7:3] ignored
- opd_empty  in  1  operand FIFO empty
- opd_rd_en  out  1  operand FIFO pop, one-cycle pulse
- opd_data  in  DATA_W  operands; [255:128] = B, [127:0] = A
- core_a, core_b  out  OP_W  registered operands to Core2
- core_sel  out  SEL_W  registered select to Core2
- core_start  out  1  one-cycle start pulse
- core_busy  in  1  Core2 busy; high from the cycle after start until the result is valid
- core_result  in  DATA_W  Core2 result, valid when core_busy falls
- res_full  in  1  output FIFO full
- res_wr_en  out  1  output FIFO push, one-cycle pulse
- res_data  out  DATA_W  registered result
- ctrl_idle  out  1  high in IDLE
- err_flag  out  1  sticky watchdog error
- op_count  out  16  results written, wraps 0xFFFF→0

## Operation
- FIFOs have registered reads: data is valid in the cycle after rd_en.
- IDLE: when !cmd_empty && !opd_empty, pulse cmd_rd_en and opd_rd_en in the same cycle, then go to FETCH. If either FIFO is empty, nothing is popped.
- FETCH: wait one cycle, then go to LATCH.
- LATCH: register core_sel=cmd_data[2:0], core_b=opd_data[255:128], core_a=opd_data[127:0]. Go to ISSUE.
- ISSUE: core_start=1 for one cycle. Go to WAIT.
- WAIT: core_busy is ignored in the first WAIT cycle. From then on, when core_busy=0, capture core_result into res_data and go to WRITE.
- WRITE: if !res_full, pulse res_wr_en, increment op_count, and go to IDLE. If res_full, hold res_wr_en low and keep res_data stable.
- core_a, core_b and core_sel hold their values until the next LATCH.
- Exactly one operation is in flight. No pop occurs outside IDLE.

## Timing
- Reset value of every output is 0, except ctrl_idle, which is 1. State resets to IDLE and op_count to 0.
- Cycle numbering: IDLE pop at c0, FETCH c1, LATCH c2, core_start c3, first WAIT cycle c4.
- With core_busy high for L cycles (c4..c3+L), the result is captured at c4+L. res_wr_en pulses at c5+L when not full.
- Minimum issue-to-issue interval is L+6 cycles.
- Reset mid-operation: the next cycle is IDLE with reset outputs. Entries already popped are discarded. Upstream FIFOs are not reset by this block.
- res_full falling and a new operation available in the same cycle: the write completes first, and the pop happens the following cycle in IDLE.

## Configuration
- CORE2_WATCHDOG_EN defined:
  - A WAIT-cycle counter runs against WD_CYCLES.
  - When the counter reaches WD_CYCLES, err_flag is set (sticky until rst), the operation is dropped with no write and no op_count increment, and the state returns to IDLE.
- CORE2_WATCHDOG_EN undefined:
  - There is no counter.
  - err_flag is tied to 0 and WAIT waits indefinitely.

## Structure
- Package core2_ctrl_pkg holds:
  - the state encoding (IDLE, FETCH, LATCH, ISSUE, WAIT, WRITE)
  - width constants
  - the select field position in cmd_data
  - the operand split positions
- Optional sub-module core2_watchdog: counter, limit compare and sticky flag, instantiated only under CORE2_WATCHDOG_EN.

## Test plan
- Single operation:
  - Stimulus: cmd 0x02, opd B=0x2 / A=0x1, core_busy high 3 cycles, result 0xABCD.
  - Response: core_sel=2, core_a=1, core_b=2, core_start at c3, res_wr_en at c8 with 0xABCD, op_count=1.
- Output backpressure:
  - Stimulus: res_full high for 5 cycles in WRITE.
  - Response: no res_wr_en and res_data stable during those cycles; push on the cycle after res_full falls; no pops meanwhile.
- Operand starvation:
  - Stimulus: command present, operand FIFO empty for 10 cycles.
  - Response: no rd_en and ctrl_idle=1; when the operand arrives, both rd_en pulse together.
- Three back-to-back operations with distinct results:
  - Response: three writes in order, three pulses on each rd_en, op_count=3.
- Watchdog (macro on, WD_CYCLES=16):
  - Stimulus: core_busy stuck high.
  - Response: err_flag=1 after 16 WAIT cycles, no write, return to IDLE. With the macro off, the controller remains in WAIT.
- Reset mid-operation:
  - Stimulus: rst asserted during WAIT.
  - Response: all outputs at reset values next cycle, IDLE, op_count=0.
